button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Sits between the raw controller pins and the UI FSMs (user-interface and homescreen FSMs); feeds their `buttons` input.
- Synchronises, debounces and edge-detects the 8 GuyBox buttons, and generates auto-repeat events for held D-pad buttons.
- Bit order everywhere is {Start, C, B, A, Right, Left, Down, Up}.
- UI FSMs consume `btn_event`, which is a one-cycle pulse per logical press or repeat, so one press advances a menu by exactly one step.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable synced cycles required to accept a level change (≥2).
- REPEAT_DELAY, 25000000, cycles a repeat-enabled button must be held after its press before the first repeat event (≥2).
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat events (≥2).
- REPEAT_MASK, 8'h0F, bits that auto-repeat (D-pad only).

Ports:
- clk  in  1  system clock; the single clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  event enable; when low, pulses are suppressed and repeat is cancelled.
- raw_buttons  in  8  asynchronous button inputs, 1 = pressed (board inversion is done upstream).
- btn_level  out  8  debounced level, 1 = held.
- btn_press  out  8  one-cycle pulse on the debounced 0→1 transition.
- btn_release  out  8  one-cycle pulse on the debounced 1→0 transition.
- btn_event  out  8  btn_press OR auto-repeat pulse; the bus the UI FSMs consume.

Behaviour:
- Reset (rst=0, async):
  - All synchronizer flops, debounced state, counters and outputs are cleared to 0.
  - All repeat FSMs go to IDLE.
  - A button held through reset deassertion is seen as a new press after debounce; this is intended.
- Synchronizer: two flops per bit; `sync` lags `raw_buttons` by 2 cycles.
- Debounce (per bit):
  - A counter increments while `sync != btn_level` and clears to 0 in any cycle where `sync == btn_level`.
  - When the counter would reach DEBOUNCE_CYCLES, `btn_level` toggles and the counter clears in that same edge.
  - A glitch shorter than DEBOUNCE_CYCLES never changes `btn_level`.
  - Latency from a clean raw edge to `btn_level`: 2 + DEBOUNCE_CYCLES cycles.
  - The counter saturates safely; its width is clog2(DEBOUNCE_CYCLES+1).
- Edge pulses:
  - `btn_press[i]` = 1 for exactly the first cycle `btn_level[i]` = 1; `btn_release[i]` likewise for the first cycle it is 0.
  - Both are registered, aligned with the `btn_level` change, and gated by `en`.
  - `btn_level` is never gated by `en`.
- Repeat FSM (per bit with REPEAT_MASK[i]=1; other bits stay in IDLE). States IDLE, DELAY, REPEAT; one shared-width cycle counter per bit.
  - IDLE → DELAY on `btn_press[i]` (en=1), counter loads 0.
  - DELAY: counter increments each cycle. When it reaches REPEAT_DELAY-1, emit a repeat pulse on the next cycle, go to REPEAT, and clear the counter.
    - First repeat is REPEAT_DELAY cycles after the press pulse.
  - REPEAT: counter increments. At REPEAT_PERIOD-1, pulse on the next cycle and clear the counter.
  - Any state → IDLE immediately when `btn_level[i]`=0 or en=0. No pulse is emitted in the cycle of the release.
- `btn_event[i]` = `btn_press[i]` | `repeat_pulse[i]`, registered and at most one cycle high per event.
  - Press and repeat never coincide.
- Simultaneous events: bits are fully independent; any number of bits may pulse in the same cycle.
- `en` falling mid-hold: pulses stop the same cycle. `en` rising while a button is held produces no press pulse; it needs a new debounced press.
- Reset mid-operation clears everything regardless of state; no pulse is emitted on reset exit.

Decomposition:
- Package `guybox_input_pkg`:
  - Button index localparams: BTN_UP=0, BTN_DOWN=1, BTN_LEFT=2, BTN_RIGHT=3, BTN_A=4, BTN_B=5, BTN_C=6, BTN_START=7.
  - NUM_BUTTONS=8.
  - Default timing constants for a 50 MHz clock.
- Sub-module `button_debounce_bit`: single-bit synchronizer, debounce counter and edge pulses. Instantiated 8× in a generate loop.
- The repeat FSM stays in the top-level generate.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, en=1 unless noted):
- Clean press: raw[A] 0→1 at cycle 0 and held → `btn_level[4]` and `btn_press[4]` rise at cycle 6. `btn_press` is high for 1 cycle. No repeats for bit 4.
- Bounce rejection: raw[Up] toggles 1,0,1,0 for 3 cycles each, then stays 0 → `btn_level` stays 0. No press or release pulse.
- Auto-repeat: hold Down from cycle 0 → `btn_event[1]` pulses at 6 (press), then at 16, 19, 22… until release. On release, `btn_release[1]` pulses once and events stop.
- Simultaneous: raw Start and Right rise in the same cycle → `btn_press[7]` and `btn_press[3]` pulse in the same cycle. Only bit 3 repeats.
- Enable gating: hold Left, deassert en at cycle 12 → no `btn_event[2]` after cycle 12, `btn_level[2]` stays 1. Reassert en → no event until release plus a new press.
- Async reset mid-repeat: assert rst=0 during REPEAT → all outputs 0 immediately. With the button still held after rst=1, the press pulse appears 6 cycles later.

Source files
------------

// File: rtl/guybox_input_pkg.sv
// guybox_input_pkg
//   Shared definitions for the GuyBox button input path: button indices,
//   bus width, default timing for a 50 MHz clk, and the per-button
//   auto-repeat state encoding.
//   Bit order on every button bus: {Start, C, B, A, Right, Left, Down, Up}.
package guybox_input_pkg;

  localparam int NUM_BUTTONS = 8;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_START = 7;

  // 50 MHz: 5 ms debounce, 500 ms to first repeat, 100 ms repeat period.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;
  localparam int DEFAULT_REPEAT_DELAY    = 25000000;
  localparam int DEFAULT_REPEAT_PERIOD   = 5000000;

  // Only the D-pad auto-repeats.
  localparam logic [NUM_BUTTONS-1:0] DEFAULT_REPEAT_MASK = 8'h0F;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// button_conditioner_if
//   Bundles the button path between the pin side and the UI FSMs.
//   Signals:
//     en          event enable (pulses suppressed while low)
//     raw_buttons asynchronous button pins, 1 = pressed
//     btn_level   debounced level, 1 = held
//     btn_press   one-cycle pulse on debounced press
//     btn_release one-cycle pulse on debounced release
//     btn_event   press or auto-repeat pulse, consumed by the UI FSMs
//   Modports:
//     master  side driving pins/enable and observing the results
//     slave   the conditioner itself
interface button_conditioner_if;
  import guybox_input_pkg::*;

  logic                   en;
  logic [NUM_BUTTONS-1:0] raw_buttons;
  logic [NUM_BUTTONS-1:0] btn_level;
  logic [NUM_BUTTONS-1:0] btn_press;
  logic [NUM_BUTTONS-1:0] btn_release;
  logic [NUM_BUTTONS-1:0] btn_event;

  modport master (
    output en,
    output raw_buttons,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_event
  );

  modport slave (
    input  en,
    input  raw_buttons,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_event
  );

endinterface

// File: rtl/button_debounce_bit.sv
// button_debounce_bit
//   One button: two-flop synchronizer, stable-count debounce and
//   registered press/release pulses.
//   Ports:
//     clk, rst   system clock, async active-low reset
//     en_i       pulse enable (level is never gated)
//     raw_i      asynchronous button pin
//     level_o    debounced level (registered)
//     press_o    registered pulse, first cycle level_o = 1
//     release_o  registered pulse, first cycle level_o = 0
//     level_d_o  next value of level_o (same-edge view for the repeat FSM)
//     rise_o     next value of press_o (same-edge view for the repeat FSM)
module button_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic level_d_o,
  output logic rise_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_q;
  logic          sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q    <= 1'b0;
      sync_q    <= 1'b0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      meta_q    <= raw_i;
      sync_q    <= meta_q;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // The count only survives consecutive mismatching cycles; the >= compare
  // keeps it from wrapping even if it were ever corrupted past the limit.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q != level_q) begin
      if (cnt_q >= CNT_LAST) begin
        level_d = ~level_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d   = en_i & level_d & ~level_q;
    release_d = en_i & ~level_d & level_q;
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign level_d_o = level_d;
  assign rise_o    = press_d;

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner
//   Synchronises, debounces and edge-detects the 8 GuyBox buttons and
//   adds auto-repeat events for held repeat-enabled buttons.
//   Ports:
//     clk   system clock
//     rst   asynchronous active-low reset
//     bus   button_conditioner_if.slave (en, raw_buttons in;
//           btn_level, btn_press, btn_release, btn_event out)
//
//   Repeat FSM (one per button):
//     state      | meaning
//     RPT_IDLE   | not held, disabled, or not a repeat button
//     RPT_DELAY  | held since press, counting to the first repeat
//     RPT_REPEAT | held past the first repeat, emitting every period
module button_conditioner
  import guybox_input_pkg::*;
#(
  parameter int                     DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int                     REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int                     REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD,
  parameter logic [NUM_BUTTONS-1:0] REPEAT_MASK     = DEFAULT_REPEAT_MASK
) (
  input  logic                 clk,
  input  logic                 rst,
  button_conditioner_if.slave  bus
);

  localparam int RCW = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [RCW-1:0] DELAY_LAST  = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] PERIOD_LAST = RCW'(REPEAT_PERIOD - 1);

  logic [NUM_BUTTONS-1:0] level_w;
  logic [NUM_BUTTONS-1:0] press_w;
  logic [NUM_BUTTONS-1:0] release_w;
  logic [NUM_BUTTONS-1:0] level_d_w;
  logic [NUM_BUTTONS-1:0] rise_w;
  logic [NUM_BUTTONS-1:0] event_q;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn

    button_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk       (clk),
      .rst       (rst),
      .en_i      (bus.en),
      .raw_i     (bus.raw_buttons[i]),
      .level_o   (level_w[i]),
      .press_o   (press_w[i]),
      .release_o (release_w[i]),
      .level_d_o (level_d_w[i]),
      .rise_o    (rise_w[i])
    );

    rpt_state_e     state_q, state_d;
    logic [RCW-1:0] cnt_q, cnt_d;
    logic           rep_d;
    logic           hold;

    // Looking at the next debounced level means the FSM drops out on the
    // same edge the release pulse is registered, so a repeat due in that
    // cycle is never emitted. Masked-off bits are pinned to IDLE.
    assign hold = bus.en & level_d_w[i] & REPEAT_MASK[i];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q    <= RPT_IDLE;
        cnt_q      <= '0;
        event_q[i] <= 1'b0;
      end else begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        event_q[i] <= rise_w[i] | rep_d;
      end
    end

    // Entering DELAY on the same edge as the press pulse makes the counter
    // read 0 during the press cycle, so the first repeat lands exactly
    // REPEAT_DELAY cycles after the press.
    always_comb begin
      state_d = state_q;
      if (!hold) begin
        state_d = RPT_IDLE;
      end else begin
        case (state_q)
          RPT_IDLE:   if (rise_w[i]) state_d = RPT_DELAY;
          RPT_DELAY:  if (cnt_q == DELAY_LAST) state_d = RPT_REPEAT;
          RPT_REPEAT: state_d = RPT_REPEAT;
          default:    state_d = RPT_IDLE;
        endcase
      end
    end

    always_comb begin
      cnt_d = cnt_q + 1'b1;
      rep_d = 1'b0;
      case (state_q)
        RPT_IDLE: cnt_d = '0;
        RPT_DELAY: begin
          if (cnt_q == DELAY_LAST) begin
            rep_d = 1'b1;
            cnt_d = '0;
          end
        end
        RPT_REPEAT: begin
          if (cnt_q == PERIOD_LAST) begin
            rep_d = 1'b1;
            cnt_d = '0;
          end
        end
        default: cnt_d = '0;
      endcase
      if (!hold) begin
        cnt_d = '0;
        rep_d = 1'b0;
      end
    end

  end

  assign bus.btn_level   = level_w;
  assign bus.btn_press   = press_w;
  assign bus.btn_release = release_w;
  assign bus.btn_event   = event_q;

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_pass;

  typedef struct {
    int         cyc;
    logic [7:0] press;
    logic [7:0] rel;
    logic [7:0] ev;
  } exp_t;

  exp_t q[$];

  button_conditioner_if bif ();

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3),
    .REPEAT_MASK    (8'h0F)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic push(input int c, input logic [7:0] p, input logic [7:0] r, input logic [7:0] e);
    exp_t x;
    x.cyc = c; x.press = p; x.rel = r; x.ev = e;
    q.push_back(x);
  endtask

  task automatic at(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0d: got %h expected %h", name, cyc, act, exp);
  endtask

  // Scoreboard monitor: any pulse on the output buses must match the
  // expectation scheduled for this exact cycle, and every scheduled
  // expectation must be met in its cycle.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      n_checks++;
      $display("FAIL missed_event: expected at cycle %0d press=%h rel=%h ev=%h, not observed", e.cyc, e.press, e.rel, e.ev);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      n_checks++;
      if (bif.btn_press === e.press && bif.btn_release === e.rel && bif.btn_event === e.ev)
        n_pass++;
      else
        $display("FAIL pulses@%0d: got press=%h rel=%h ev=%h expected press=%h rel=%h ev=%h",
                 cyc, bif.btn_press, bif.btn_release, bif.btn_event, e.press, e.rel, e.ev);
    end else if ((bif.btn_press | bif.btn_release | bif.btn_event) !== 8'h00) begin
      n_checks++;
      $display("FAIL unexpected_pulse@%0d: got press=%h rel=%h ev=%h expected all 00",
               cyc, bif.btn_press, bif.btn_release, bif.btn_event);
    end
  end

  initial begin
    int t;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b0;
    bif.en = 1'b1;
    bif.raw_buttons = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check8("reset_level",   bif.btn_level,   8'h00);
    check8("reset_press",   bif.btn_press,   8'h00);
    check8("reset_release", bif.btn_release, 8'h00);
    check8("reset_event",   bif.btn_event,   8'h00);
    rst = 1'b1;
    at(cyc + 3);

    // Clean press and release of A: no repeats on a non-D-pad bit.
    t = cyc;
    bif.raw_buttons[4] = 1'b1;
    push(t + 6, 8'h10, 8'h00, 8'h10);
    at(t + 5);  check8("a_level_before", bif.btn_level, 8'h00);
    at(t + 6);  check8("a_level_rise",   bif.btn_level, 8'h10);
    at(t + 30); bif.raw_buttons[4] = 1'b0;
    push(t + 36, 8'h00, 8'h10, 8'h00);
    at(t + 37); check8("a_level_fall",   bif.btn_level, 8'h00);
    at(t + 45);

    // Bounce on Up: 3-cycle runs never reach the 4-cycle threshold.
    t = cyc;
    bif.raw_buttons[0] = 1'b1;
    at(t + 3); bif.raw_buttons[0] = 1'b0;
    at(t + 6); bif.raw_buttons[0] = 1'b1;
    at(t + 9); bif.raw_buttons[0] = 1'b0;
    at(t + 12); check8("bounce_level_mid", bif.btn_level, 8'h00);
    at(t + 20); check8("bounce_level_end", bif.btn_level, 8'h00);

    // Auto-repeat on Down; release lands on a cycle where a repeat was due.
    t = cyc;
    bif.raw_buttons[1] = 1'b1;
    push(t + 6,  8'h02, 8'h00, 8'h02);
    push(t + 16, 8'h00, 8'h00, 8'h02);
    push(t + 19, 8'h00, 8'h00, 8'h02);
    push(t + 22, 8'h00, 8'h00, 8'h02);
    push(t + 25, 8'h00, 8'h00, 8'h02);
    push(t + 28, 8'h00, 8'h00, 8'h02);
    at(t + 25); bif.raw_buttons[1] = 1'b0;
    push(t + 31, 8'h00, 8'h02, 8'h00);
    at(t + 40);

    // Start and Right together: both press, only Right repeats.
    t = cyc;
    bif.raw_buttons[7] = 1'b1;
    bif.raw_buttons[3] = 1'b1;
    push(t + 6,  8'h88, 8'h00, 8'h88);
    push(t + 16, 8'h00, 8'h00, 8'h08);
    push(t + 19, 8'h00, 8'h00, 8'h08);
    push(t + 22, 8'h00, 8'h00, 8'h08);
    at(t + 17);
    bif.raw_buttons[7] = 1'b0;
    bif.raw_buttons[3] = 1'b0;
    push(t + 23, 8'h00, 8'h88, 8'h00);
    at(t + 35);

    // Enable gating on Left: repeats cancelled, re-enable gives nothing
    // until a fresh press.
    t = cyc;
    bif.raw_buttons[2] = 1'b1;
    push(t + 6, 8'h04, 8'h00, 8'h04);
    at(t + 12); bif.en = 1'b0;
    at(t + 20); check8("en_off_level", bif.btn_level, 8'h04);
    at(t + 25); bif.en = 1'b1;
    at(t + 30); bif.raw_buttons[2] = 1'b0;
    push(t + 36, 8'h00, 8'h04, 8'h00);
    at(t + 40); bif.raw_buttons[2] = 1'b1;
    push(t + 46, 8'h04, 8'h00, 8'h04);
    at(t + 48); bif.raw_buttons[2] = 1'b0;
    push(t + 54, 8'h00, 8'h04, 8'h00);
    at(t + 60);

    // Async reset while Up is repeating; held button re-presses afterwards.
    t = cyc;
    bif.raw_buttons[0] = 1'b1;
    push(t + 6,  8'h01, 8'h00, 8'h01);
    push(t + 16, 8'h00, 8'h00, 8'h01);
    push(t + 19, 8'h00, 8'h00, 8'h01);
    at(t + 20);
    check8("pre_rst_level", bif.btn_level, 8'h01);
    rst = 1'b0;
    #1;
    check8("rst_level",   bif.btn_level,   8'h00);
    check8("rst_press",   bif.btn_press,   8'h00);
    check8("rst_release", bif.btn_release, 8'h00);
    check8("rst_event",   bif.btn_event,   8'h00);
    at(t + 23); rst = 1'b1;
    push(t + 29, 8'h01, 8'h00, 8'h01);
    at(t + 31); bif.raw_buttons[0] = 1'b0;
    push(t + 37, 8'h00, 8'h01, 8'h00);
    at(t + 45);

    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      $display("FAIL leftover_event: expected at cycle %0d press=%h rel=%h ev=%h, never checked", e.cyc, e.press, e.rel, e.ev);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
